// File: rtl/seg_scroll_ctrl.sv
// Scrolling-text controller for a multi-digit 7-segment display.
// Holds a message of 6-bit character codes and presents a NUM_DIGITS-wide window
// that moves right-to-left over the message plus a trailing blank gap. The window
// repeats until scrolling is stopped.
module seg_scroll_ctrl #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned MSG_DEPTH  = 32,
    parameter int unsigned TICK_DIV   = 25000000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wr_valid_i,
    output logic                    wr_ready_o,
    input  logic [5:0]              wr_char_i,
    input  logic                    wr_last_i,
    input  logic                    start_i,
    input  logic                    stop_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [6*NUM_DIGITS-1:0] chars_o
);

    // pos/len width; AW adds one bit so L = len + NUM_DIGITS and pos + k never overflow
    localparam int unsigned PW = $clog2(MSG_DEPTH + NUM_DIGITS);
    localparam int unsigned AW = PW + 1;
    localparam int unsigned BW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] LEN_MAX    = PW'(MSG_DEPTH);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] DIGITS_EXT = AW'(NUM_DIGITS);
    localparam logic [5:0]    CHAR_BLANK = 6'd36;

    typedef enum logic [1:0] {StIdle, StLoad, StReady, StScroll} state_t;

    state_t        r_state;
    logic [PW-1:0] r_len;
    logic [PW-1:0] r_pos;
    logic [TW-1:0] r_tick;
    logic          r_busy;
    logic          r_done;
    logic [5:0]    r_chars [NUM_DIGITS];
    logic [5:0]    r_buf   [MSG_DEPTH];

    logic          w_wr_ready;
    logic          w_accept;
    logic          w_start;
    logic [PW-1:0] w_len_next;
    logic          w_fill_done;
    logic [BW-1:0] w_wr_idx;
    logic [AW-1:0] w_len_ext;
    logic [AW-1:0] w_pos_ext;
    logic [AW-1:0] w_l;
    logic          w_pos_last;
    logic [AW-1:0] w_idx [NUM_DIGITS];
    logic [5:0]    w_win [NUM_DIGITS];

    // Write handshake, next-length and scroll-geometry helpers
    always_comb begin
        w_wr_ready  = (r_state != StScroll) && (r_len < LEN_MAX);
        w_accept    = wr_valid_i && w_wr_ready;
        // Stop always beats start
        w_start     = start_i && !stop_i;
        // A beat in IDLE/READY begins a fresh message; in LOAD it appends
        w_len_next  = (r_state == StLoad) ? (r_len + PW'(1)) : PW'(1);
        w_fill_done = wr_last_i || (w_len_next == LEN_MAX);
        w_wr_idx    = (r_state == StLoad) ? r_len[BW-1:0] : '0;
        w_len_ext   = {1'b0, r_len};
        w_pos_ext   = {1'b0, r_pos};
        w_l         = w_len_ext + DIGITS_EXT;
        w_pos_last  = (w_pos_ext == (w_l - AW'(1)));
    end

    // Window lookup: V[(pos+k) mod L], where V is the message followed by blanks
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_idx[k] = w_pos_ext + AW'(k);
            // pos + k < 2L, so one conditional subtract is a full modulo
            if (w_idx[k] >= w_l) begin
                w_idx[k] = w_idx[k] - w_l;
            end
            w_win[k] = (w_idx[k] < w_len_ext) ? r_buf[w_idx[k][BW-1:0]] : CHAR_BLANK;
        end
    end

    // Message storage; no reset needed because len=0 marks it empty
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_buf[w_wr_idx] <= wr_char_i;
        end
    end

    // Control FSM with registered busy/done/window outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_len   <= '0;
            r_pos   <= '0;
            r_tick  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                r_chars[k] <= CHAR_BLANK;
            end
        end else begin
            r_done <= 1'b0;

            // Window follows pos one cycle later; blank outside scrolling and on stop
            for (int k = 0; k < NUM_DIGITS; k++) begin
                r_chars[k] <= (r_state == StScroll && !stop_i) ? w_win[k] : CHAR_BLANK;
            end

            case (r_state)
                StIdle, StLoad: begin
                    if (w_accept) begin
                        r_len   <= w_len_next;
                        r_state <= w_fill_done ? StReady : StLoad;
                    end
                end
                StReady: begin
                    // A write takes precedence over start
                    if (w_accept) begin
                        r_len   <= w_len_next;
                        r_state <= w_fill_done ? StReady : StLoad;
                    end else if (w_start) begin
                        r_state <= StScroll;
                        r_busy  <= 1'b1;
                        r_pos   <= '0;
                        r_tick  <= '0;
                    end
                end
                StScroll: begin
                    if (stop_i) begin
                        r_state <= StReady;
                        r_busy  <= 1'b0;
                    end else if (start_i) begin
                        r_pos  <= '0;
                        r_tick <= '0;
                    end else if (r_tick == TICK_LAST) begin
                        r_tick <= '0;
                        if (w_pos_last) begin
                            r_pos  <= '0;
                            r_done <= 1'b1;
                        end else begin
                            r_pos <= r_pos + PW'(1);
                        end
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Pack digit 0 into the most significant slice
    always_comb begin
        chars_o = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            chars_o[6*(NUM_DIGITS-1-k) +: 6] = r_chars[k];
        end
    end

    assign wr_ready_o = w_wr_ready;
    assign busy_o     = r_busy;
    assign done_o     = r_done;

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Bench for seg_scroll_ctrl with NUM_DIGITS=4, MSG_DEPTH=8, TICK_DIV=4.
// Stimulus queues the expected windows (with hold lengths) and wrap gaps; a
// negedge monitor pops and compares them whenever chars_o changes or done_o fires.
module tb_seg_scroll_ctrl;

    localparam int unsigned ND = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          wr_valid_i = 1'b0;
    logic          wr_ready_o;
    logic [5:0]    wr_char_i = '0;
    logic          wr_last_i = 1'b0;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic [6*ND-1:0] chars_o;

    seg_scroll_ctrl #(
        .NUM_DIGITS (4),
        .MSG_DEPTH  (8),
        .TICK_DIV   (4)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_valid_i (wr_valid_i),
        .wr_ready_o (wr_ready_o),
        .wr_char_i  (wr_char_i),
        .wr_last_i  (wr_last_i),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .chars_o    (chars_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [23:0] win;
        int          dur;   // expected hold in cycles, 0 = not checked
    } item_t;

    item_t exp_q[$];
    int    exp_done[$];

    int n_checks = 0;
    int n_errors = 0;

    logic        mon_en = 1'b0;
    logic [23:0] mon_last;
    logic        mon_have = 1'b0;
    int          mon_dur = 0;
    int          mon_hold = 0;
    int          mon_since = 0;
    logic        mon_busy_last = 1'b0;

    logic [23:0] blank_w;
    logic [23:0] hi_w [6];
    logic [23:0] five_w [5];
    logic [23:0] ovf_w [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] w4(input int a, input int b, input int c, input int d);
        logic [5:0] ca, cb, cc, cd;
        ca = a[5:0];
        cb = b[5:0];
        cc = c[5:0];
        cd = d[5:0];
        return {ca, cb, cc, cd};
    endfunction

    task automatic push_win(input logic [23:0] w, input int d);
        item_t it;
        it.win = w;
        it.dur = d;
        exp_q.push_back(it);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic beat(input int ch, input logic last);
        wr_valid_i = 1'b1;
        wr_char_i  = ch[5:0];
        wr_last_i  = last;
        #1;
        check("wr_ready_beat", {31'b0, wr_ready_o}, 32'd1);
        cyc();
        wr_valid_i = 1'b0;
        wr_last_i  = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
    endtask

    // Monitor: compare each new window and each wrap pulse against the queues
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (chars_o !== mon_last) begin
                if (mon_have && mon_dur != 0) begin
                    check("window_hold", mon_hold, mon_dur);
                end
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL window_unexpected: got %h expected none", chars_o);
                    mon_have = 1'b0;
                end else begin
                    item_t it;
                    it = exp_q.pop_front();
                    check("window", {8'b0, chars_o}, {8'b0, it.win});
                    mon_dur  = it.dur;
                    mon_have = 1'b1;
                end
                mon_hold = 1;
            end else begin
                mon_hold++;
            end
            mon_last = chars_o;

            if (busy_o && !mon_busy_last) mon_since = 0;
            else mon_since++;
            if (done_o) begin
                if (exp_done.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL done_unexpected: got pulse expected none at %0t", $time);
                end else begin
                    check("done_gap", mon_since, exp_done.pop_front());
                end
                mon_since = 0;
            end
            mon_busy_last = busy_o;
        end
    end

    initial begin
        blank_w = w4(36, 36, 36, 36);
        // "HI": V = 17 18 _ _ _ _, L = 6
        hi_w[0] = w4(17, 18, 36, 36);
        hi_w[1] = w4(18, 36, 36, 36);
        hi_w[2] = w4(36, 36, 36, 36);
        hi_w[3] = w4(36, 36, 36, 17);
        hi_w[4] = w4(36, 36, 17, 18);
        hi_w[5] = w4(36, 17, 18, 36);
        // "5": V = 5 _ _ _ _, L = 5
        five_w[0] = w4(5, 36, 36, 36);
        five_w[1] = w4(36, 36, 36, 36);
        five_w[2] = w4(36, 36, 36, 5);
        five_w[3] = w4(36, 36, 5, 36);
        five_w[4] = w4(36, 5, 36, 36);
        // Full message 10..17: V = 10..17 _ _ _ _, L = 12
        ovf_w[0]  = w4(10, 11, 12, 13);
        ovf_w[1]  = w4(11, 12, 13, 14);
        ovf_w[2]  = w4(12, 13, 14, 15);
        ovf_w[3]  = w4(13, 14, 15, 16);
        ovf_w[4]  = w4(14, 15, 16, 17);
        ovf_w[5]  = w4(15, 16, 17, 36);
        ovf_w[6]  = w4(16, 17, 36, 36);
        ovf_w[7]  = w4(17, 36, 36, 36);
        ovf_w[8]  = w4(36, 36, 36, 36);
        ovf_w[9]  = w4(36, 36, 36, 10);
        ovf_w[10] = w4(36, 36, 10, 11);
        ovf_w[11] = w4(36, 10, 11, 12);

        // Asynchronous reset asserted mid-cycle
        repeat (2) cyc();
        #3;
        rst_i = 1'b1;
        #1;
        check("rst_chars", {8'b0, chars_o}, {8'b0, blank_w});
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_done", {31'b0, done_o}, 32'd0);
        check("rst_wr_ready", {31'b0, wr_ready_o}, 32'd1);
        cyc();
        cyc();
        rst_i = 1'b0;
        mon_last = blank_w;
        mon_busy_last = 1'b0;
        mon_en = 1'b1;

        // Load "HI"; start in LOAD must be ignored
        beat(17, 1'b0);
        pulse_start();
        check("start_in_load", {31'b0, busy_o}, 32'd0);
        beat(18, 1'b1);
        check("ready_wr_ready", {31'b0, wr_ready_o}, 32'd1);

        // Two full periods, then stop+start together during pos 0
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 6; p++) push_win(hi_w[p], 4);
        end
        push_win(hi_w[0], 0);
        push_win(blank_w, 0);
        exp_done.push_back(24);
        exp_done.push_back(24);
        pulse_start();
        check("scroll_busy", {31'b0, busy_o}, 32'd1);
        check("scroll_wr_ready", {31'b0, wr_ready_o}, 32'd0);
        repeat (50) cyc();
        stop_i  = 1'b1;
        start_i = 1'b1;
        cyc();
        stop_i  = 1'b0;
        start_i = 1'b0;
        check("stop_busy", {31'b0, busy_o}, 32'd0);
        check("stop_chars", {8'b0, chars_o}, {8'b0, blank_w});

        // Start from READY, then restart mid-scroll during pos 1
        push_win(hi_w[0], 4);
        push_win(hi_w[1], 2);
        push_win(hi_w[0], 4);
        push_win(hi_w[1], 1);
        push_win(blank_w, 0);
        pulse_start();
        check("restart_busy", {31'b0, busy_o}, 32'd1);
        repeat (5) cyc();
        pulse_start();
        repeat (5) cyc();
        stop_i = 1'b1;
        cyc();
        stop_i = 1'b0;

        // Replacement write coinciding with start: write wins
        wr_valid_i = 1'b1;
        wr_char_i  = 6'd5;
        wr_last_i  = 1'b1;
        start_i    = 1'b1;
        #1;
        check("replace_wr_ready", {31'b0, wr_ready_o}, 32'd1);
        cyc();
        wr_valid_i = 1'b0;
        wr_last_i  = 1'b0;
        start_i    = 1'b0;
        check("write_beats_start", {31'b0, busy_o}, 32'd0);

        // Scroll "5" (period 20) while a write is held off
        for (int p = 0; p < 5; p++) push_win(five_w[p], 4);
        push_win(five_w[0], 2);
        push_win(blank_w, 0);
        exp_done.push_back(20);
        pulse_start();
        repeat (10) cyc();
        wr_valid_i = 1'b1;
        wr_char_i  = 6'd7;
        wr_last_i  = 1'b1;
        #1;
        check("scroll_blocks_write", {31'b0, wr_ready_o}, 32'd0);
        repeat (12) cyc();
        check("scroll_blocks_write_late", {31'b0, wr_ready_o}, 32'd0);
        stop_i = 1'b1;
        cyc();
        stop_i = 1'b0;
        check("pending_ready_after_stop", {31'b0, wr_ready_o}, 32'd1);
        cyc();
        wr_valid_i = 1'b0;
        wr_last_i  = 1'b0;

        // Pending beat replaced the message with "7"
        push_win(w4(7, 36, 36, 36), 2);
        push_win(blank_w, 0);
        pulse_start();
        repeat (2) cyc();
        stop_i = 1'b1;
        cyc();
        stop_i = 1'b0;

        // Overflow: 8 beats fill the buffer, the 9th stays pending
        for (int i = 0; i < 8; i++) beat(10 + i, 1'b0);
        wr_valid_i = 1'b1;
        wr_char_i  = 6'd18;
        #1;
        check("full_refuses", {31'b0, wr_ready_o}, 32'd0);
        repeat (2) cyc();
        check("full_refuses_late", {31'b0, wr_ready_o}, 32'd0);
        check("full_not_busy", {31'b0, busy_o}, 32'd0);

        for (int p = 0; p < 12; p++) push_win(ovf_w[p], 4);
        push_win(ovf_w[0], 0);
        exp_done.push_back(48);
        start_i = 1'b1;
        cyc();
        start_i    = 1'b0;
        wr_valid_i = 1'b0;
        check("full_start_busy", {31'b0, busy_o}, 32'd1);
        repeat (50) cyc();

        // Reset in the middle of scrolling
        mon_en = 1'b0;
        #3;
        rst_i = 1'b1;
        #1;
        check("midrst_chars", {8'b0, chars_o}, {8'b0, blank_w});
        check("midrst_busy", {31'b0, busy_o}, 32'd0);
        check("midrst_done", {31'b0, done_o}, 32'd0);
        check("midrst_wr_ready", {31'b0, wr_ready_o}, 32'd1);
        cyc();
        rst_i = 1'b0;
        pulse_start();
        check("idle_ignores_start", {31'b0, busy_o}, 32'd0);
        check("idle_chars", {8'b0, chars_o}, {8'b0, blank_w});

        check("windows_drained", exp_q.size(), 32'd0);
        check("dones_drained", exp_done.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
